// File: rtl/ctrl_pipe_if.sv
// Control-bundle interface between the ID-stage decoders, the hazard unit,
// the EX-stage ALU flags and the pipelined control registers.
interface ctrl_pipe_if #(
  parameter int unsigned CNT_W = 32
);
  logic             validD;
  logic             regWriteD;
  logic             memWriteD;
  logic [1:0]       resultSrcD;
  logic [1:0]       ALUSrcD;
  logic [2:0]       ALUControlD;
  logic             branchD;
  logic             jalD;
  logic             jalrD;
  logic [2:0]       funct3D;
  logic             flushE;
  logic             zeroE;
  logic             negE;

  logic [1:0]       ALUSrcE;
  logic [2:0]       ALUControlE;
  logic [1:0]       resultSrcE;
  logic             regWriteE;
  logic [1:0]       PCSrcE;
  logic             takenE;
  logic             regWriteM;
  logic             memWriteM;
  logic [1:0]       resultSrcM;
  logic             regWriteW;
  logic [1:0]       resultSrcW;
  logic [CNT_W-1:0] instret;

  modport master (
    output validD, regWriteD, memWriteD, resultSrcD, ALUSrcD, ALUControlD,
           branchD, jalD, jalrD, funct3D, flushE, zeroE, negE,
    input  ALUSrcE, ALUControlE, resultSrcE, regWriteE, PCSrcE, takenE,
           regWriteM, memWriteM, resultSrcM, regWriteW, resultSrcW, instret
  );

  modport slave (
    input  validD, regWriteD, memWriteD, resultSrcD, ALUSrcD, ALUControlD,
           branchD, jalD, jalrD, funct3D, flushE, zeroE, negE,
    output ALUSrcE, ALUControlE, resultSrcE, regWriteE, PCSrcE, takenE,
           regWriteM, memWriteM, resultSrcM, regWriteW, resultSrcW, instret
  );
endinterface

// File: rtl/ctrl_pipe.sv
// Pipelines the decoded control word through ID/EX, EX/MEM and MEM/WB,
// resolves control transfers in EX and counts retired instructions.
module ctrl_pipe #(
  parameter int unsigned CNT_W = 32
) (
  input  logic         clk,
  input  logic         rst,
  ctrl_pipe_if.slave   bus
);

  localparam int unsigned SEL_W = 2;
  localparam int unsigned ALU_W = 3;
  localparam int unsigned F3_W  = 3;

  logic             validE_q, regWriteE_q, memWriteE_q;
  logic [SEL_W-1:0] resultSrcE_q, ALUSrcE_q;
  logic [ALU_W-1:0] ALUControlE_q;
  logic             branchE_q, jalE_q, jalrE_q;
  logic [F3_W-1:0]  funct3E_q;

  logic             validM_q, regWriteM_q, memWriteM_q;
  logic [SEL_W-1:0] resultSrcM_q;

  logic             validW_q, regWriteW_q;
  logic [SEL_W-1:0] resultSrcW_q;

  logic [CNT_W-1:0] instret_q, instret_d;

  logic             cond_met_c;
  logic [SEL_W-1:0] pc_src_c;
  logic             taken_c;
  logic             bubble_c;

  // Branch condition and PC-source selection from the word currently in EX
  always_comb begin
    cond_met_c = 1'b0;
    pc_src_c   = 2'b00;
    case (funct3E_q)
      3'b000:  cond_met_c = bus.zeroE;
      3'b001:  cond_met_c = ~bus.zeroE;
      3'b100:  cond_met_c = bus.negE;
      3'b101:  cond_met_c = ~bus.negE;
      default: cond_met_c = 1'b0;
    endcase
    if (jalrE_q && validE_q) begin
      pc_src_c = 2'b10;
    end else if ((jalE_q && validE_q) || (branchE_q && validE_q && cond_met_c)) begin
      pc_src_c = 2'b01;
    end
  end

  assign taken_c  = (pc_src_c != 2'b00);
  assign bubble_c = bus.flushE | taken_c;

  // ID/EX: a flush and a taken transfer on the same edge collapse to one bubble
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      validE_q      <= 1'b0;
      regWriteE_q   <= 1'b0;
      memWriteE_q   <= 1'b0;
      resultSrcE_q  <= '0;
      ALUSrcE_q     <= '0;
      ALUControlE_q <= '0;
      branchE_q     <= 1'b0;
      jalE_q        <= 1'b0;
      jalrE_q       <= 1'b0;
      funct3E_q     <= '0;
    end else if (bubble_c) begin
      validE_q      <= 1'b0;
      regWriteE_q   <= 1'b0;
      memWriteE_q   <= 1'b0;
      resultSrcE_q  <= '0;
      ALUSrcE_q     <= '0;
      ALUControlE_q <= '0;
      branchE_q     <= 1'b0;
      jalE_q        <= 1'b0;
      jalrE_q       <= 1'b0;
      funct3E_q     <= '0;
    end else begin
      validE_q      <= bus.validD;
      regWriteE_q   <= bus.regWriteD;
      memWriteE_q   <= bus.memWriteD;
      resultSrcE_q  <= bus.resultSrcD;
      ALUSrcE_q     <= bus.ALUSrcD;
      ALUControlE_q <= bus.ALUControlD;
      branchE_q     <= bus.branchD;
      jalE_q        <= bus.jalD;
      jalrE_q       <= bus.jalrD;
      funct3E_q     <= bus.funct3D;
    end
  end

  // EX/MEM and MEM/WB never stall
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      validM_q     <= 1'b0;
      regWriteM_q  <= 1'b0;
      memWriteM_q  <= 1'b0;
      resultSrcM_q <= '0;
      validW_q     <= 1'b0;
      regWriteW_q  <= 1'b0;
      resultSrcW_q <= '0;
    end else begin
      validM_q     <= validE_q;
      regWriteM_q  <= regWriteE_q;
      memWriteM_q  <= memWriteE_q;
      resultSrcM_q <= resultSrcE_q;
      validW_q     <= validM_q;
      regWriteW_q  <= regWriteM_q;
      resultSrcW_q <= resultSrcM_q;
    end
  end

  assign instret_d = validW_q ? instret_q + CNT_W'(1) : instret_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) instret_q <= '0;
    else      instret_q <= instret_d;
  end

  assign bus.ALUSrcE     = ALUSrcE_q;
  assign bus.ALUControlE = ALUControlE_q;
  assign bus.resultSrcE  = resultSrcE_q;
  assign bus.regWriteE   = regWriteE_q;
  assign bus.PCSrcE      = pc_src_c;
  assign bus.takenE      = taken_c;
  assign bus.regWriteM   = regWriteM_q;
  assign bus.memWriteM   = memWriteM_q;
  assign bus.resultSrcM  = resultSrcM_q;
  assign bus.regWriteW   = regWriteW_q;
  assign bus.resultSrcW  = resultSrcW_q;
  assign bus.instret     = instret_q;

endmodule

// File: doc/ctrl_pipe.md
Name: ctrl_pipe

Overview:
- Receiving end of the main controller's decoded control bundle: registers the ID-stage control word through the ID/EX, EX/MEM and MEM/WB boundaries.
- Resolves branches and jumps in EX from ALU zero/neg flags.
- Inserts bubbles on hazard-unit flush or taken control transfer.
- Counts retired instructions.
- Sits between the main/ALU controllers and the datapath pipeline registers.

Parameters:
- CNT_W, 32, width of retired-instruction counter instret (wraps modulo 2^CNT_W).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-low reset (0 = reset)
- validD  in  1  ID holds a real instruction
- regWriteD  in  1  register-file write enable
- memWriteD  in  1  data-memory write enable
- resultSrcD  in  2  WB mux select (00 ALU, 01 mem, 10 ALU/imm, 11 PC+4)
- ALUSrcD  in  2  ALU operand-B select
- ALUControlD  in  3  ALU operation
- branchD, jalD, jalrD  in  1 each  control-transfer type
- funct3D  in  3  branch condition
- flushE  in  1  hazard-unit bubble request for ID/EX (load-use)
- zeroE, negE  in  1 each  ALU flags for the instruction in EX
- ALUSrcE  out  2;  ALUControlE  out  3;  resultSrcE  out  2 (load-use detection)
- regWriteE  out  1 (forwarding/hazard use)
- PCSrcE  out  2  00 PC+4, 01 PC+imm target, 10 jalr target
- takenE  out  1  PCSrcE != 00; hazard unit flushes IF/ID
- regWriteM, memWriteM  out  1 each;  resultSrcM  out  2
- regWriteW  out  1;  resultSrcW  out  2
- instret  out  CNT_W  retired-instruction count

Behaviour:
- Reset (rst=0, asynchronous): all stage registers clear to 0 (valid bits, enables, selects, branch/jal/jalr, funct3). instret = 0. PCSrcE = 00, takenE = 0. Release is synchronous to the next clk edge.
- Latency: a D-stage word appears at E one cycle later, M two, W three. No stall of EX/MEM/WB; every stage advances each cycle.
- ID/EX load on every edge, with one exception. A bubble is loaded instead when flushE=1 or takenE=1 on that edge.
  - Bubble: validE=0; regWriteE, memWriteE, branchE, jalE, jalrE = 0; other fields 0.
  - flushE and takenE together produce a single bubble.
  - A branch must never bubble itself: takenE is evaluated from the word currently in E.
- EX/MEM and MEM/WB copy the previous stage unconditionally, including valid.
- Branch resolution (combinational from E registers):
  - funct3 000 beq: zeroE
  - 001 bne: !zeroE
  - 100 blt: negE
  - 101 bge: !negE
  - any other funct3: not taken
  - condE = branchE & validE & the condition above
- PCSrcE priority: jalrE&validE → 10; else (jalE&validE)|condE → 01; else 00.
- jalE and jalrE both set: jalr wins. branch with jal/jalr set: jal/jalr wins.
- instret increments by 1 on each edge where validW=1. It wraps from 2^CNT_W-1 to 0. Bubbles are never counted.
- Reset mid-operation discards all in-flight words; instret returns to 0.

Test Plan:
- Reset: hold rst=0 with random inputs → all outputs 0, instret=0. Release rst, drive add (validD=1, regWriteD=1, resultSrcD=10, ALUControlD=010) one cycle → regWriteE=1 at +1, regWriteM=1 at +2, regWriteW=1/resultSrcW=10 at +3, instret=1 at +4.
- beq taken: branchD=1, funct3D=000; in E drive zeroE=1 → PCSrcE=01, takenE=1. Following D word (regWriteD=1) enters E as bubble: regWriteE=0, never reaches W, instret +1 only for the branch.
- bne not taken / bge taken: funct3=001 with zeroE=1 → PCSrcE=00. funct3=101 with negE=0 → PCSrcE=01. funct3=010 with any flags → PCSrcE=00.
- jalr vs jal: jalrD=1 → PCSrcE=10, resultSrcW=11 three cycles later. jalD=jalrD=1 → PCSrcE=10.
- Load-use: lw (resultSrcD=01, regWriteD=1) then flushE=1 for one cycle → resultSrcE=01 visible before the bubble, next E word has validE=0. Same cycle as takenE=1 → exactly one bubble.
- Counter wrap: CNT_W=4, retire 17 valid instructions → instret reads 15 then 0 then 1. Assert rst low mid-stream → instret=0 immediately, no W-stage write enables for 3 cycles after release without new validD.
